mem_initiator: RTL and testbench



---
 rtl/mem_initiator.sv | 100 ++++++++++
 tb/tb_mem_initiator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// Requester for a 64x8 sync-write / comb-read data memory: one load/store at a
// time, direct or pointer-indirect, with a valid/ready response and error flag.
module mem_initiator #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [2:0] {IDLE, PTR, RD, WR, RESP} state_t;

  state_t              state_q;
  logic                is_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   tgt_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                ptr_bad;

  // Shift form keeps this legal when DATA_W == ADDR_W (no upper bits at all).
  assign ptr_bad = (mem_out >> ADDR_W) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      tgt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            is_wr_q <= req_op[0];
            addr_q  <= req_addr;
            tgt_q   <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= 1'b0;
            if (req_op[1])      state_q <= PTR;
            else if (req_op[0]) state_q <= WR;
            else                state_q <= RD;
          end
        end
        PTR: begin
          if (ptr_bad) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= RESP;
          end else begin
            tgt_q   <= mem_out[ADDR_W-1:0];
            state_q <= is_wr_q ? WR : RD;
          end
        end
        RD: begin
          rdata_q <= mem_out;
          state_q <= RESP;
        end
        WR: begin
          rdata_q <= wdata_q;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Everything below decodes registered state only, so reset drops mem_we at once.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;
  assign mem_we    = (state_q == WR);
  assign mem_data  = (state_q == WR) ? wdata_q : '0;
  assign mem_addr  = (state_q == PTR) ? addr_q :
                     ((state_q == RD) || (state_q == WR)) ? tgt_q : '0;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: attached 64x8 memory plus an array-based reference model.
module tb_mem_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, mem_we;
  logic [1:0] req_op;
  logic [5:0] req_addr, mem_addr;
  logic [7:0] req_wdata, rsp_data, mem_data, mem_out;

  logic [7:0] tb_mem  [64];
  logic [7:0] ref_mem [64];
  logic       pre_we = 1'b0;
  logic [5:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_initiator #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out)
  );

  always @(posedge clk) begin
    if (pre_we)      tb_mem[pre_addr] <= pre_data;
    else if (mem_we) tb_mem[mem_addr] <= mem_data;
  end
  assign mem_out = tb_mem[mem_addr];

  task automatic preload(input logic [5:0] a, input logic [7:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    ref_mem[a] = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // One full transaction with zero response stall, checked against the model.
  task automatic do_req(input logic [1:0] op, input logic [5:0] a, input logic [7:0] wd, input string tag);
    logic [7:0] exp_data, ptr, got_data, w_data;
    logic [5:0] tgt, w_addr;
    logic       exp_err, got_err;
    int         exp_lat, exp_we, lat, we_cnt;
    bit         got;
    tgt = a; exp_err = 1'b0; exp_lat = 2;
    if (op[1]) begin
      ptr = ref_mem[a];
      if (ptr > 8'd63) exp_err = 1'b1;
      else begin tgt = ptr[5:0]; exp_lat = 3; end
    end
    if (exp_err)    begin exp_data = 8'h00; exp_we = 0; end
    else if (op[0]) begin ref_mem[tgt] = wd; exp_data = wd; exp_we = 1; end
    else            begin exp_data = ref_mem[tgt]; exp_we = 0; end

    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL %s req_ready got=%b want=1", tag, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = 6'($urandom); req_wdata = 8'($urandom);
    got = 1'b0; lat = 0; we_cnt = 0; got_data = '0; got_err = 1'b0; w_addr = '0; w_data = '0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_we === 1'b1) begin we_cnt++; w_addr = mem_addr; w_data = mem_data; end
      if (rsp_valid === 1'b1) begin got = 1'b1; lat = c; got_data = rsp_data; got_err = rsp_err; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL %s timeout got=no_rsp want=rsp", tag); end
    total++;
    if (lat != exp_lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", tag, lat, exp_lat); end
    total++;
    if (got_data !== exp_data) begin bad++; $display("FAIL %s rsp_data got=%h want=%h", tag, got_data, exp_data); end
    total++;
    if (got_err !== exp_err) begin bad++; $display("FAIL %s rsp_err got=%b want=%b", tag, got_err, exp_err); end
    total++;
    if (we_cnt != exp_we) begin bad++; $display("FAIL %s we_cycles got=%0d want=%0d", tag, we_cnt, exp_we); end
    if (exp_we == 1) begin
      total++;
      if (w_addr !== tgt || w_data !== wd) begin
        bad++; $display("FAIL %s we_bus got=%h/%h want=%h/%h", tag, w_addr, w_data, tgt, wd);
      end
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL %s post_rsp got=v%b/r%b want=v0/r1", tag, rsp_valid, req_ready);
    end
    total++;
    if (tb_mem[tgt] !== ref_mem[tgt]) begin
      bad++; $display("FAIL %s mem[%h] got=%h want=%h", tag, tgt, tb_mem[tgt], ref_mem[tgt]);
    end
    $display("txn %s op=%b addr=%h wd=%h -> data=%h err=%b lat=%0d", tag, op, a, wd, got_data, got_err, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 6'h00 || rsp_data !== 8'h00) begin
      bad++; $display("FAIL reset_pre got=r%b v%b we%b a%h d%h want=r1 v0 we0 a00 d00", req_ready, rsp_valid, mem_we, mem_addr, rsp_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 6'h00 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_post got=r%b v%b we%b a%h e%b want=r1 v0 we0 a00 e0", req_ready, rsp_valid, mem_we, mem_addr, rsp_err);
    end
    $display("txn reset done");
  endtask

  task automatic test_direct();
    do_req(2'b01, 6'h05, 8'hA7, "dir_wr");
    do_req(2'b00, 6'h05, 8'h00, "dir_rd");
  endtask

  task automatic test_indirect();
    preload(6'h10, 8'h3F);
    preload(6'h3F, 8'h5C);
    do_req(2'b10, 6'h10, 8'h00, "ind_rd");
    do_req(2'b11, 6'h10, 8'h11, "ind_wr");
    total++;
    if (tb_mem[6'h10] !== 8'h3F) begin bad++; $display("FAIL ind_wr_ptr got=%h want=3f", tb_mem[6'h10]); end
    preload(6'h2A, 8'h2A);
    do_req(2'b11, 6'h2A, 8'h15, "ind_self");
  endtask

  task automatic test_ptr_err();
    preload(6'h02, 8'h80);
    do_req(2'b11, 6'h02, 8'hFF, "ptr_err_wr");
    total++;
    if (tb_mem[6'h02] !== 8'h80) begin bad++; $display("FAIL ptr_err_mem got=%h want=80", tb_mem[6'h02]); end
    do_req(2'b10, 6'h02, 8'h00, "ptr_err_rd");
  endtask

  task automatic test_stall();
    logic [7:0] exp_d;
    bit         got;
    exp_d = ref_mem[6'h20];
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 6'h20; rsp_ready = 1'b0;
    @(posedge clk); #1;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL stall_rsp got=no_rsp want=rsp"); end
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_op = 2'($urandom); req_addr = 6'($urandom); req_wdata = 8'($urandom);
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || req_ready !== 1'b0 || mem_we !== 1'b0) begin
        bad++; $display("FAIL stall_hold got=v%b d%h r%b we%b want=v1 d%h r0 we0", rsp_valid, rsp_data, req_ready, mem_we, exp_d);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b01; req_addr = 6'h09; req_wdata = 8'h33;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release got=r%b v%b want=r1 v0", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    ref_mem[6'h09] = 8'h33;
    @(negedge clk);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 6'h09 || mem_data !== 8'h33) begin
      bad++; $display("FAIL stall_next got=we%b a%h d%h want=we1 a09 d33", mem_we, mem_addr, mem_data);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (tb_mem[6'h09] !== 8'h33 || req_ready !== 1'b1) begin
      bad++; $display("FAIL stall_next_done got=%h r%b want=33 r1", tb_mem[6'h09], req_ready);
    end
    $display("txn stall read addr=20 data=%h then write 09=33", exp_d);
  endtask

  task automatic test_reset_mid_write();
    preload(6'h07, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_addr = 6'h07; req_wdata = 8'h22; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (mem_we !== 1'b1) begin bad++; $display("FAIL rst_wr_entry got=we%b want=we1", mem_we); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (mem_we !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid got=we%b r%b v%b want=we0 r1 v0", mem_we, req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (tb_mem[6'h07] !== 8'h00 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mem got=%h r%b want=00 r1", tb_mem[6'h07], req_ready);
    end
    $display("txn reset mid write addr=07 mem=%h", tb_mem[6'h07]);
    do_req(2'b00, 6'h07, 8'h00, "rst_readback");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [5:0] a;
      op = 2'($urandom);
      a  = 6'($urandom);
      if ($urandom_range(0, 2) == 0) preload(a, 8'($urandom_range(0, 63)));
      do_req(op, a, 8'($urandom), "rand");
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 64; i++) preload(6'(i), 8'($urandom));
    test_direct();
    test_indirect();
    test_ptr_err();
    test_stall();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
